xcfi_retire_checker: RTL and testbench
======================================

XCFI_RETIRE_CHECKER -- requirements
Module: xcfi_retire_checker

Interface
REQ-001 Parameter: NRET, default 2, number of retirement channels (1..4).
REQ-002 Parameter: XLEN, default 32, datapath width.
REQ-003 Parameter: CW, default 16, width of retired-instruction counter.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 check_en  in  1  when high, detected violations are recorded; tracking continues regardless.
REQ-007 rvfi_valid  in  NRET  per-channel retirement valid.
REQ-008 rvfi_order  in  NRET*64  per-channel retirement index.
REQ-009 rvfi_intr  in  NRET  per-channel first instruction of a trap handler.
REQ-010 rvfi_pc_rdata, rvfi_pc_wdata  in  NRET*XLEN each  per-channel PC before / after.
REQ-011 rvfi_rd_addr  in  NRET*5; rvfi_rd_wdata  in  NRET*XLEN  per-channel destination.
REQ-012 err_pc, err_order, err_x0, err_lane  out  1 each  sticky violation flags.
REQ-013 err_any  out  1  OR of all four error flags.
REQ-014 first_err_order  out  64  rvfi_order of first recorded violation.
REQ-015 retired  out  CW  saturating count of retired instructions.
REQ-016 state  out  2  IDLE=0, TRACK=1, ERROR=2.

Function
REQ-017 Channel slice k: bits [k*W +: W] of each packed bus.
REQ-018 Lane rule: channel k valid with any channel j<k invalid -> lane violation.
REQ-019 Valid channels processed in ascending index within a cycle.
REQ-020 Expected PC for channel k: pc_wdata of nearest lower valid channel same cycle, else exp_pc register.
REQ-021 PC violation: valid channel, rvfi_intr low, pc_rdata != expected PC; not checked in IDLE for channel 0.
REQ-022 Expected order for channel k: exp_order + (number of valid channels below k), modulo 2^64; order violation on mismatch; not checked in IDLE.
REQ-023 x0 violation: valid channel with rd_addr==0 and rd_wdata!=0.
REQ-024 IDLE: first cycle with any valid channel -> TRACK; exp_pc/exp_order loaded from highest valid channel (pc_wdata, order+1).
REQ-025 TRACK: each cycle with any valid channel, exp_pc <= pc_wdata of highest valid channel; exp_order <= exp_order + popcount(rvfi_valid), wrapping at 2^64.
REQ-026 TRACK -> ERROR when check_en high and any violation detected that cycle.
REQ-027 ERROR absorbing until reset; error flags, first_err_order, exp_pc, exp_order frozen; retired still counts.
REQ-028 Violations with check_en low: no flags set, no state change.
REQ-029 Multiple violations same cycle: all corresponding flags set together; first_err_order = rvfi_order of lowest-index violating channel.
REQ-030 Violation in IDLE cycle (lane, x0) with check_en high -> ERROR directly, flags set.
REQ-031 retired += popcount(rvfi_valid) each cycle, saturating at 2^CW-1, never wraps.
REQ-032 Flag/state outputs registered: visible cycle after violating retirement; no combinational input-to-output path.

Reset
REQ-033 resetn low: state=IDLE, all err_* =0, first_err_order=0, retired=0, exp_pc=0, exp_order=0, asynchronously.
REQ-034 Reset assertion mid-ERROR or mid-cycle discards all tracking; first retirement after deassertion re-enters REQ-024.

Verification
REQ-035 NRET=2; cycle1 ch0 pc 0x100->0x104 order 0; cycle2 ch0 pc 0x104->0x108 order 1, ch1 pc 0x108->0x10C order 2 -> no errors, state=TRACK, retired=3.
REQ-036 TRACK, exp_pc 0x10C; ch0 pc_rdata 0x200, intr=0, check_en=1 -> next cycle err_pc=1, state=ERROR, first_err_order=ch0 order.
REQ-037 Same as REQ-036 but intr=1 -> no error; exp_pc follows pc_wdata.
REQ-038 rvfi_valid=2'b10 with check_en=1 -> err_lane=1; same with check_en=0 -> no flag, state unchanged.
REQ-039 ch0 rd_addr=0 rd_wdata=5 and ch1 order mismatch same cycle -> err_x0=1, err_order=1, first_err_order=ch0 order.
REQ-040 CW=2, four single retirements -> retired=3 after third, stays 3; exp_order 0xFFFF_FFFF_FFFF_FFFF then 0 accepted without error.

Source files
------------

// File: rtl/xcfi_retire_checker.sv
// Retirement-stream consistency checker: tracks PC and order continuity across
// NRET in-order retirement channels and latches sticky violation flags.
module xcfi_retire_checker #(
  parameter int NRET = 2,
  parameter int XLEN = 32,
  parameter int CW   = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 check_en,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*64-1:0]   rvfi_order,
  input  logic [NRET-1:0]      rvfi_intr,
  input  logic [NRET*XLEN-1:0] rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0] rvfi_pc_wdata,
  input  logic [NRET*5-1:0]    rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
  output logic                 err_pc,
  output logic                 err_order,
  output logic                 err_x0,
  output logic                 err_lane,
  output logic                 err_any,
  output logic [63:0]          first_err_order,
  output logic [CW-1:0]        retired,
  output logic [1:0]           state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] exp_pc_q, exp_pc_d;
  logic [63:0]     exp_order_q, exp_order_d;
  logic [63:0]     first_err_order_q, first_err_order_d;
  logic [CW-1:0]   retired_q, retired_d;
  logic            err_pc_q, err_pc_d, err_order_q, err_order_d;
  logic            err_x0_q, err_x0_d, err_lane_q, err_lane_d;

  logic [XLEN-1:0] run_pc;
  logic [63:0]     run_ord, last_ord, viol_ord;
  logic            seen_gap, viol_found;
  logic            ch_pc, ch_ord, ch_x0, ch_lane;
  logic            v_pc, v_order, v_x0, v_lane;
  logic [2:0]      valid_cnt;
  logic            any_valid, record;
  logic [CW+2:0]   ret_sum;

  // Walk channels in ascending order; each valid channel becomes the reference
  // PC/order for the next one, so run_* ends at the post-cycle expectation.
  always_comb begin
    run_pc     = exp_pc_q;
    run_ord    = exp_order_q;
    last_ord   = '0;
    viol_ord   = '0;
    seen_gap   = 1'b0;
    viol_found = 1'b0;
    ch_pc      = 1'b0;
    ch_ord     = 1'b0;
    ch_x0      = 1'b0;
    ch_lane    = 1'b0;
    v_pc       = 1'b0;
    v_order    = 1'b0;
    v_x0       = 1'b0;
    v_lane     = 1'b0;
    valid_cnt  = '0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid[k]) begin
        ch_lane = seen_gap;
        ch_pc   = !rvfi_intr[k] && (rvfi_pc_rdata[k*XLEN +: XLEN] != run_pc)
                  && !(state_q == S_IDLE && k == 0);
        ch_ord  = (state_q != S_IDLE) && (rvfi_order[k*64 +: 64] != run_ord);
        ch_x0   = (rvfi_rd_addr[k*5 +: 5] == 5'd0) && (rvfi_rd_wdata[k*XLEN +: XLEN] != '0);
        v_pc    = v_pc | ch_pc;
        v_order = v_order | ch_ord;
        v_x0    = v_x0 | ch_x0;
        v_lane  = v_lane | ch_lane;
        if (!viol_found && (ch_pc || ch_ord || ch_x0 || ch_lane)) begin
          viol_found = 1'b1;
          viol_ord   = rvfi_order[k*64 +: 64];
        end
        run_pc    = rvfi_pc_wdata[k*XLEN +: XLEN];
        run_ord   = run_ord + 64'd1;
        last_ord  = rvfi_order[k*64 +: 64];
        valid_cnt = valid_cnt + 3'd1;
      end else begin
        seen_gap = 1'b1;
      end
    end
  end

  assign any_valid = |rvfi_valid;
  assign record    = check_en && viol_found && (state_q != S_ERROR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (record) state_d = S_ERROR; else if (any_valid) state_d = S_TRACK;
      S_TRACK: if (record) state_d = S_ERROR;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Tracking registers and flags; everything except retired freezes in ERROR.
  always_comb begin
    exp_pc_d          = exp_pc_q;
    exp_order_d       = exp_order_q;
    err_pc_d          = err_pc_q;
    err_order_d       = err_order_q;
    err_x0_d          = err_x0_q;
    err_lane_d        = err_lane_q;
    first_err_order_d = first_err_order_q;
    if (state_q != S_ERROR && any_valid) begin
      exp_pc_d    = run_pc;
      exp_order_d = (state_q == S_IDLE) ? last_ord + 64'd1 : run_ord;
    end
    if (record) begin
      err_pc_d          = v_pc;
      err_order_d       = v_order;
      err_x0_d          = v_x0;
      err_lane_d        = v_lane;
      first_err_order_d = viol_ord;
    end
    ret_sum = {3'b000, retired_q} + {{CW{1'b0}}, valid_cnt};
    if (ret_sum > {3'b000, {CW{1'b1}}}) retired_d = {CW{1'b1}};
    else                                retired_d = ret_sum[CW-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q           <= S_IDLE;
      exp_pc_q          <= '0;
      exp_order_q       <= '0;
      first_err_order_q <= '0;
      retired_q         <= '0;
      err_pc_q          <= 1'b0;
      err_order_q       <= 1'b0;
      err_x0_q          <= 1'b0;
      err_lane_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      exp_pc_q          <= exp_pc_d;
      exp_order_q       <= exp_order_d;
      first_err_order_q <= first_err_order_d;
      retired_q         <= retired_d;
      err_pc_q          <= err_pc_d;
      err_order_q       <= err_order_d;
      err_x0_q          <= err_x0_d;
      err_lane_q        <= err_lane_d;
    end
  end

  always_comb begin
    state           = state_q;
    err_pc          = err_pc_q;
    err_order       = err_order_q;
    err_x0          = err_x0_q;
    err_lane        = err_lane_q;
    err_any         = err_pc_q | err_order_q | err_x0_q | err_lane_q;
    first_err_order = first_err_order_q;
    retired         = retired_q;
  end

endmodule

// File: tb/tb_xcfi_retire_checker.sv
// Directed bench for xcfi_retire_checker: main instance (CW=16) plus a CW=2
// instance sharing the same stimulus for counter saturation.
module tb_xcfi_retire_checker;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         check_en;
  logic [1:0]   rvfi_valid, rvfi_intr;
  logic [127:0] rvfi_order;
  logic [63:0]  rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [9:0]   rvfi_rd_addr;

  logic         err_pc, err_order, err_x0, err_lane, err_any;
  logic [63:0]  first_err_order;
  logic [15:0]  retired;
  logic [1:0]   state;

  logic         s_err_pc, s_err_order, s_err_x0, s_err_lane, s_err_any;
  logic [63:0]  s_first_err_order;
  logic [1:0]   s_retired;
  logic [1:0]   s_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  xcfi_retire_checker #(.NRET(2), .XLEN(32), .CW(16)) dut (
    .clock(clock), .resetn(resetn), .check_en(check_en),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .err_pc(err_pc), .err_order(err_order), .err_x0(err_x0), .err_lane(err_lane),
    .err_any(err_any), .first_err_order(first_err_order), .retired(retired), .state(state)
  );

  xcfi_retire_checker #(.NRET(2), .XLEN(32), .CW(2)) dut_sat (
    .clock(clock), .resetn(resetn), .check_en(check_en),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .err_pc(s_err_pc), .err_order(s_err_order), .err_x0(s_err_x0), .err_lane(s_err_lane),
    .err_any(s_err_any), .first_err_order(s_first_err_order), .retired(s_retired), .state(s_state)
  );

  task automatic clear_inputs();
    rvfi_valid    = '0;
    rvfi_intr     = '0;
    rvfi_order    = '0;
    rvfi_pc_rdata = '0;
    rvfi_pc_wdata = '0;
    rvfi_rd_addr  = '0;
    rvfi_rd_wdata = '0;
  endtask

  task automatic set_ch(input int k, input logic [63:0] ord, input logic [31:0] pcr,
                        input logic [31:0] pcw, input logic [4:0] rd,
                        input logic [31:0] wd, input logic it);
    rvfi_valid[k]              = 1'b1;
    rvfi_order[k*64 +: 64]     = ord;
    rvfi_pc_rdata[k*32 +: 32]  = pcr;
    rvfi_pc_wdata[k*32 +: 32]  = pcw;
    rvfi_rd_addr[k*5 +: 5]     = rd;
    rvfi_rd_wdata[k*32 +: 32]  = wd;
    rvfi_intr[k]               = it;
  endtask

  // Clock the current inputs in, sample 1ns after the edge, then idle the bus.
  task automatic step();
    @(posedge clock);
    #1;
    $display("cycle: valid=%b en=%b -> state=%0d err=%b%b%b%b retired=%0d first=%h",
             rvfi_valid, check_en, state, err_pc, err_order, err_x0, err_lane,
             retired, first_err_order);
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    check_en = 1'b1;
    resetn   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", state); miscompares++; end
    vectors++; if (err_any !== 1'b0) begin $display("FAIL reset_err_any: got %b want 0", err_any); miscompares++; end
    vectors++; if (retired !== 16'd0) begin $display("FAIL reset_retired: got %0d want 0", retired); miscompares++; end
    vectors++; if (first_err_order !== 64'd0) begin $display("FAIL reset_first: got %h want 0", first_err_order); miscompares++; end
  endtask

  task automatic test_basic_track();
    set_ch(0, 64'd0, 32'h100, 32'h104, 5'd1, 32'h11, 1'b0);
    step();
    vectors++; if (state !== 2'd1) begin $display("FAIL basic_c1_state: got %0d want 1", state); miscompares++; end
    vectors++; if (retired !== 16'd1) begin $display("FAIL basic_c1_retired: got %0d want 1", retired); miscompares++; end
    set_ch(0, 64'd1, 32'h104, 32'h108, 5'd2, 32'h22, 1'b0);
    set_ch(1, 64'd2, 32'h108, 32'h10C, 5'd3, 32'h33, 1'b0);
    step();
    vectors++; if (err_any !== 1'b0) begin $display("FAIL basic_err_any: got %b want 0", err_any); miscompares++; end
    vectors++; if (state !== 2'd1) begin $display("FAIL basic_state: got %0d want 1", state); miscompares++; end
    vectors++; if (retired !== 16'd3) begin $display("FAIL basic_retired: got %0d want 3", retired); miscompares++; end
  endtask

  task automatic test_intr_and_pc_error();
    // trap entry: discontinuous PC tolerated, expectation follows pc_wdata
    set_ch(0, 64'd3, 32'h200, 32'h204, 5'd1, 32'h1, 1'b1);
    step();
    vectors++; if (err_any !== 1'b0 || state !== 2'd1) begin $display("FAIL intr_no_err: got err=%b state=%0d want err=0 state=1", err_any, state); miscompares++; end
    set_ch(0, 64'd4, 32'h204, 32'h208, 5'd1, 32'h1, 1'b0);
    step();
    vectors++; if (err_any !== 1'b0) begin $display("FAIL intr_follow: got err=%b want 0", err_any); miscompares++; end
    set_ch(0, 64'd5, 32'h300, 32'h304, 5'd1, 32'h1, 1'b0);
    step();
    vectors++; if (err_pc !== 1'b1 || err_order !== 1'b0 || err_x0 !== 1'b0 || err_lane !== 1'b0) begin $display("FAIL pc_flags: got %b%b%b%b want 1000", err_pc, err_order, err_x0, err_lane); miscompares++; end
    vectors++; if (state !== 2'd2) begin $display("FAIL pc_state: got %0d want 2", state); miscompares++; end
    vectors++; if (first_err_order !== 64'd5) begin $display("FAIL pc_first: got %h want 5", first_err_order); miscompares++; end
    // ERROR absorbs: later x0 violation ignored, retired still counts
    set_ch(0, 64'd77, 32'h999, 32'h99C, 5'd0, 32'h5, 1'b0);
    step();
    vectors++; if (err_x0 !== 1'b0 || first_err_order !== 64'd5 || state !== 2'd2) begin $display("FAIL error_frozen: got x0=%b first=%h state=%0d want 0/5/2", err_x0, first_err_order, state); miscompares++; end
    vectors++; if (retired !== 16'd7) begin $display("FAIL error_retired: got %0d want 7", retired); miscompares++; end
  endtask

  task automatic test_lane();
    do_reset();
    set_ch(0, 64'd10, 32'h40, 32'h44, 5'd1, 32'h1, 1'b0);
    step();
    check_en = 1'b0;
    set_ch(1, 64'd11, 32'h44, 32'h48, 5'd1, 32'h1, 1'b0);
    step();
    vectors++; if (err_any !== 1'b0 || state !== 2'd1) begin $display("FAIL lane_disabled: got err=%b state=%0d want 0/1", err_any, state); miscompares++; end
    check_en = 1'b1;
    set_ch(1, 64'd12, 32'h48, 32'h4C, 5'd1, 32'h1, 1'b0);
    step();
    vectors++; if (err_lane !== 1'b1 || err_pc !== 1'b0 || err_order !== 1'b0 || err_x0 !== 1'b0) begin $display("FAIL lane_flags: got %b%b%b%b want 0001", err_pc, err_order, err_x0, err_lane); miscompares++; end
    vectors++; if (state !== 2'd2 || first_err_order !== 64'd12) begin $display("FAIL lane_state: got state=%0d first=%h want 2/c", state, first_err_order); miscompares++; end
  endtask

  task automatic test_multi_violation();
    do_reset();
    set_ch(0, 64'd20, 32'h80, 32'h84, 5'd1, 32'h1, 1'b0);
    step();
    set_ch(0, 64'd21, 32'h84, 32'h88, 5'd0, 32'h5, 1'b0);
    set_ch(1, 64'd99, 32'h88, 32'h8C, 5'd3, 32'h1, 1'b0);
    step();
    vectors++; if (err_x0 !== 1'b1 || err_order !== 1'b1 || err_pc !== 1'b0 || err_lane !== 1'b0) begin $display("FAIL multi_flags: got %b%b%b%b want 0110", err_pc, err_order, err_x0, err_lane); miscompares++; end
    vectors++; if (first_err_order !== 64'd21) begin $display("FAIL multi_first: got %h want 15", first_err_order); miscompares++; end
  endtask

  task automatic test_idle_violation();
    do_reset();
    set_ch(0, 64'h42, 32'h500, 32'h504, 5'd0, 32'h7, 1'b0);
    step();
    vectors++; if (state !== 2'd2 || err_x0 !== 1'b1 || err_any !== 1'b1) begin $display("FAIL idle_x0: got state=%0d x0=%b any=%b want 2/1/1", state, err_x0, err_any); miscompares++; end
    vectors++; if (first_err_order !== 64'h42) begin $display("FAIL idle_first: got %h want 42", first_err_order); miscompares++; end
  endtask

  task automatic test_wrap_saturate();
    logic [63:0] ords [4];
    logic [1:0]  want_ret [4];
    ords[0] = 64'hFFFF_FFFF_FFFF_FFFE; ords[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    ords[2] = 64'd0;                   ords[3] = 64'd1;
    want_ret[0] = 2'd1; want_ret[1] = 2'd2; want_ret[2] = 2'd3; want_ret[3] = 2'd3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ch(0, ords[i], 32'h1000 + 32'(4*i), 32'h1004 + 32'(4*i), 5'd1, 32'h1, 1'b0);
      step();
      vectors++; if (s_retired !== want_ret[i]) begin $display("FAIL sat_retired[%0d]: got %0d want %0d", i, s_retired, want_ret[i]); miscompares++; end
      vectors++; if (err_any !== 1'b0 || s_err_any !== 1'b0 || state !== 2'd1) begin $display("FAIL wrap_err[%0d]: got err=%b/%b state=%0d want 0/0/1", i, err_any, s_err_any, state); miscompares++; end
    end
    vectors++; if (retired !== 16'd4) begin $display("FAIL wide_retired: got %0d want 4", retired); miscompares++; end
  endtask

  task automatic test_async_reset();
    set_ch(0, 64'd9, 32'hDEAD0, 32'hDEAD4, 5'd1, 32'h1, 1'b0);
    step();
    vectors++; if (state !== 2'd2) begin $display("FAIL async_pre: got %0d want 2", state); miscompares++; end
    #2 resetn = 1'b0;
    #1;
    vectors++; if (state !== 2'd0 || err_any !== 1'b0 || retired !== 16'd0 || s_retired !== 2'd0) begin $display("FAIL async_reset: got state=%0d err=%b ret=%0d/%0d want 0/0/0/0", state, err_any, retired, s_retired); miscompares++; end
    @(posedge clock);
    #1 resetn = 1'b1;
    set_ch(0, 64'd50, 32'h700, 32'h704, 5'd1, 32'h1, 1'b0);
    step();
    set_ch(0, 64'd51, 32'h704, 32'h708, 5'd1, 32'h1, 1'b0);
    step();
    vectors++; if (state !== 2'd1 || err_any !== 1'b0 || retired !== 16'd2) begin $display("FAIL post_reset_track: got state=%0d err=%b ret=%0d want 1/0/2", state, err_any, retired); miscompares++; end
  endtask

  initial begin
    clear_inputs();
    check_en = 1'b1;
    test_reset();
    test_basic_track();
    test_intr_and_pc_error();
    test_lane();
    test_multi_violation();
    test_idle_violation();
    test_wrap_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
